// File: rtl/ngram_temporal_encoder_pkg.sv
// Shared constants and state type for the n-gram temporal encoder.
package ngram_temporal_encoder_pkg;

    localparam int unsigned HV_DIMENSION_DEFAULT = 2048;
    localparam int unsigned NGRAM_SIZE_DEFAULT   = 3;
    localparam int unsigned MODE_WIDTH_DEFAULT   = 2;
    localparam int unsigned LABEL_WIDTH_DEFAULT  = 8;

    // Wide enough for fill counts up to NGRAM_SIZE-1 = 7.
    localparam int unsigned FILL_CNT_WIDTH = 4;

    typedef enum logic {
        ST_FILL,
        ST_RUN
    } encState_t;

    // After reset the history is empty; only a 1-gram can emit immediately.
    function automatic encState_t resetState(input int unsigned ngramSize);
        return (ngramSize <= 1) ? ST_RUN : ST_FILL;
    endfunction

    // A segment break leaves one sample in history (fill count 1).
    function automatic encState_t segmentStartState(input int unsigned ngramSize);
        return (ngramSize <= 2) ? ST_RUN : ST_FILL;
    endfunction

endpackage

// File: rtl/hv_permute.sv
// Fixed rotation rho^SHIFT of a [0:D-1] hypervector: out[i] = in[(i-SHIFT) mod D].
module hv_permute #(
    parameter int unsigned D     = 8,
    parameter int unsigned SHIFT = 1
) (
    input  logic [0:D-1] Vector_D,
    output logic [0:D-1] Permuted_D
);

    localparam int unsigned S = SHIFT % D;

    for (genvar i = 0; i < D; i++) begin : gBit
        localparam int unsigned SRC = (i + D - S) % D;
        assign Permuted_D[i] = Vector_D[SRC];
    end

endmodule

// File: rtl/ngram_temporal_encoder.sv
// Builds n-grams S(t) ^ rho(S(t-1)) ^ ... from a stream of spatial hypervectors,
// restarting the history whenever the label or mode of the stream changes.
module ngram_temporal_encoder
    import ngram_temporal_encoder_pkg::*;
#(
    parameter int unsigned HV_DIMENSION = HV_DIMENSION_DEFAULT,
    parameter int unsigned NGRAM_SIZE   = NGRAM_SIZE_DEFAULT,
    parameter int unsigned MODE_WIDTH   = MODE_WIDTH_DEFAULT,
    parameter int unsigned LABEL_WIDTH  = LABEL_WIDTH_DEFAULT
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [MODE_WIDTH-1:0]   ModeIn_SI,
    input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [MODE_WIDTH-1:0]   ModeOut_SO,
    output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

    // One dummy history slot keeps the arrays legal for a 1-gram.
    localparam int unsigned NHIST = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
    localparam logic [FILL_CNT_WIDTH-1:0] FILL_TARGET = FILL_CNT_WIDTH'(NGRAM_SIZE - 1);

    encState_t                 state, stateNext;
    logic [FILL_CNT_WIDTH-1:0] fillCnt, fillCntNext;

    // history[0] is S(t-1), history[k] is S(t-1-k).
    logic [0:HV_DIMENSION-1]   history  [NHIST];
    logic [0:HV_DIMENSION-1]   permHist [NHIST];
    logic [MODE_WIDTH-1:0]     prevMode;
    logic [LABEL_WIDTH-1:0]    prevLabel;
    logic                      havePrev;

    logic                      accept;
    logic                      segBreak;
    logic                      loadOut;
    logic [0:HV_DIMENSION-1]   ngram;

    // rho^(k+1) of each history entry; pure wiring.
    if (NGRAM_SIZE > 1) begin : gPerm
        for (genvar k = 0; k < NGRAM_SIZE - 1; k++) begin : gStage
            hv_permute #(
                .D     (HV_DIMENSION),
                .SHIFT (k + 1)
            ) uPermute (
                .Vector_D   (history[k]),
                .Permuted_D (permHist[k])
            );
        end
    end else begin : gNoPerm
        assign permHist[0] = '0;
    end

    // State and fill counter register.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state   <= resetState(NGRAM_SIZE);
            fillCnt <= '0;
        end else begin
            state   <= stateNext;
            fillCnt <= fillCntNext;
        end
    end

    // Handshake, segment-break detection and next-state logic.
    always_comb begin
        ReadyOut_SO = ~Reset_RI & ((state == ST_FILL) | ~ValidOut_SO | ReadyIn_SI);
        accept      = ValidIn_SI & ReadyOut_SO;
        segBreak    = accept & havePrev &
                      ((ModeIn_SI != prevMode) | (LabelIn_DI != prevLabel));
        loadOut     = accept & ~segBreak & (state == ST_RUN);
        stateNext   = state;
        fillCntNext = fillCnt;
        if (segBreak) begin
            fillCntNext = FILL_CNT_WIDTH'(1);
            stateNext   = segmentStartState(NGRAM_SIZE);
        end else if (accept && (state == ST_FILL)) begin
            fillCntNext = fillCnt + 1'b1;
            if (fillCntNext == FILL_TARGET) begin
                stateNext = ST_RUN;
            end
        end
    end

    // XOR of the new sample with the permuted history.
    always_comb begin
        ngram = HypervectorIn_DI;
        for (int unsigned k = 0; k < NGRAM_SIZE - 1; k++) begin
            ngram = ngram ^ permHist[k];
        end
    end

    // History shift register and previous-sample tags.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            for (int unsigned k = 0; k < NHIST; k++) begin
                history[k] <= '0;
            end
            prevMode  <= '0;
            prevLabel <= '0;
            havePrev  <= 1'b0;
        end else if (accept) begin
            prevMode   <= ModeIn_SI;
            prevLabel  <= LabelIn_DI;
            havePrev   <= 1'b1;
            history[0] <= HypervectorIn_DI;
            for (int unsigned k = 1; k < NHIST; k++) begin
                history[k] <= segBreak ? '0 : history[k-1];
            end
        end
    end

    // Single-entry output buffer; a drain and a load in one cycle keeps it full.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            ValidOut_SO       <= 1'b0;
            ModeOut_SO        <= '0;
            LabelOut_DO       <= '0;
            HypervectorOut_DO <= '0;
        end else if (loadOut) begin
            ValidOut_SO       <= 1'b1;
            ModeOut_SO        <= ModeIn_SI;
            LabelOut_DO       <= LabelIn_DI;
            HypervectorOut_DO <= ngram;
        end else if (ReadyIn_SI) begin
            ValidOut_SO <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ngram_temporal_encoder.sv
// Directed and randomized checks of ngram_temporal_encoder against a queue-based model.
module tb_ngram_temporal_encoder;

    localparam int unsigned D  = 8;
    localparam int unsigned N  = 3;
    localparam int unsigned MW = 2;
    localparam int unsigned LW = 4;

    logic          Clk_CI = 1'b0;
    logic          Reset_RI = 1'b1;
    logic          ValidIn_SI = 1'b0;
    logic          ReadyOut_SO;
    logic [MW-1:0] ModeIn_SI = '0;
    logic [LW-1:0] LabelIn_DI = '0;
    logic [D-1:0]  HypervectorIn_DI = '0;
    logic          ValidOut_SO;
    logic          ReadyIn_SI = 1'b0;
    logic [MW-1:0] ModeOut_SO;
    logic [LW-1:0] LabelOut_DO;
    logic [D-1:0]  HypervectorOut_DO;

    ngram_temporal_encoder #(
        .HV_DIMENSION (D),
        .NGRAM_SIZE   (N),
        .MODE_WIDTH   (MW),
        .LABEL_WIDTH  (LW)
    ) dut (
        .Clk_CI            (Clk_CI),
        .Reset_RI          (Reset_RI),
        .ValidIn_SI        (ValidIn_SI),
        .ReadyOut_SO       (ReadyOut_SO),
        .ModeIn_SI         (ModeIn_SI),
        .LabelIn_DI        (LabelIn_DI),
        .HypervectorIn_DI  (HypervectorIn_DI),
        .ValidOut_SO       (ValidOut_SO),
        .ReadyIn_SI        (ReadyIn_SI),
        .ModeOut_SO        (ModeOut_SO),
        .LabelOut_DO       (LabelOut_DO),
        .HypervectorOut_DO (HypervectorOut_DO)
    );

    always #5 Clk_CI = ~Clk_CI;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    int xfers      = 0;

    // Reference model: samples of the current segment, newest first.
    bit [D-1:0]  mHist[$];
    bit          mHavePrev;
    bit [MW-1:0] mPrevMode;
    bit [LW-1:0] mPrevLabel;
    bit          mValid;
    bit [D-1:0]  mHv;
    bit [MW-1:0] mMode;
    bit [LW-1:0] mLabel;

    // Index 0 is the MSB, so rho^k is a plain right rotation of the integer value.
    function automatic bit [D-1:0] rotr(input bit [D-1:0] x, input int unsigned k);
        int unsigned s;
        s = k % D;
        if (s == 0) return x;
        return (x >> s) | (x << (D - s));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mHist.delete();
        mHavePrev  = 0;
        mPrevMode  = '0;
        mPrevLabel = '0;
        mValid     = 0;
        mHv        = '0;
        mMode      = '0;
        mLabel     = '0;
    endtask

    task automatic modelEdge(input bit acc, input bit [MW-1:0] m, input bit [LW-1:0] l,
                             input bit [D-1:0] h, input bit rdy);
        bit         loaded;
        bit [D-1:0] ng;
        loaded = 0;
        if (acc) begin
            if (mHavePrev && (m != mPrevMode || l != mPrevLabel)) begin
                mHist.delete();
                mHist.push_front(h);
            end else if (mHist.size() < int'(N) - 1) begin
                mHist.push_front(h);
            end else begin
                ng = h;
                for (int k = 0; k < int'(N) - 1; k++) ng ^= rotr(mHist[k], k + 1);
                mHv    = ng;
                mMode  = m;
                mLabel = l;
                loaded = 1;
                mHist.push_front(h);
                void'(mHist.pop_back());
            end
            mHavePrev  = 1;
            mPrevMode  = m;
            mPrevLabel = l;
        end
        if (loaded) mValid = 1;
        else if (rdy) mValid = 0;
    endtask

    task automatic checkOutputs();
        check("validOut", ValidOut_SO, mValid);
        check("hvOut", HypervectorOut_DO, mHv);
        check("modeOut", ModeOut_SO, mMode);
        check("labelOut", LabelOut_DO, mLabel);
    endtask

    // One clock cycle with the given inputs; called just after a falling edge.
    task automatic step(input bit v, input bit [MW-1:0] m, input bit [LW-1:0] l,
                        input bit [D-1:0] h, input bit rdy, output bit acc);
        bit expReady;
        Reset_RI         = 0;
        ValidIn_SI       = v;
        ModeIn_SI        = m;
        LabelIn_DI       = l;
        HypervectorIn_DI = h;
        ReadyIn_SI       = rdy;
        #1;
        expReady = (mHist.size() < int'(N) - 1) || !mValid || rdy;
        check("readyOut", ReadyOut_SO, expReady);
        if (ValidOut_SO && rdy) xfers++;
        acc = v && expReady;
        @(posedge Clk_CI);
        modelEdge(acc, m, l, h, rdy);
        @(negedge Clk_CI);
        checkOutputs();
    endtask

    task automatic doReset(input bit v);
        Reset_RI   = 1;
        ValidIn_SI = v;
        #1;
        check("readyOutInReset", ReadyOut_SO, 1'b0);
        @(posedge Clk_CI);
        modelReset();
        @(negedge Clk_CI);
        checkOutputs();
    endtask

    initial begin
        bit          acc;
        bit [D-1:0]  a, b, hv, held;
        bit [MW-1:0] curMode;
        bit [LW-1:0] curLabel;
        bit          pending;
        bit          v, rdy;

        a = 8'b1000_0000;
        b = 8'b0000_0001;
        modelReset();

        // Three equal samples give a ^ rho(a) ^ rho^2(a).
        doReset(0);
        step(1, 0, 2, a, 1, acc);
        step(1, 0, 2, a, 1, acc);
        check("t1_noEarlyOutput", ValidOut_SO, 1'b0);
        step(1, 0, 2, a, 1, acc);
        check("t1_valid", ValidOut_SO, 1'b1);
        check("t1_hv", HypervectorOut_DO, 8'b1110_0000);
        check("t1_label", LabelOut_DO, 4'd2);
        step(0, 0, 2, a, 1, acc);

        // Oldest sample b gets rotated twice.
        doReset(0);
        step(1, 0, 2, b, 1, acc);
        step(1, 0, 2, a, 1, acc);
        step(1, 0, 2, a, 1, acc);
        check("t2_hv", HypervectorOut_DO, 8'b1000_0000);

        // Label change restarts the segment.
        doReset(0);
        xfers = 0;
        for (int i = 0; i < 6; i++) step(1, 0, 2, a, 1, acc);
        step(1, 0, 3, b, 1, acc);
        check("t3_breakNoOutput", ValidOut_SO, 1'b0);
        step(0, 0, 3, b, 1, acc);
        check("t3_outputs", xfers, 4);
        step(1, 0, 3, a, 1, acc);
        check("t3_stillFilling", ValidOut_SO, 1'b0);
        step(1, 0, 3, b, 1, acc);
        check("t3_valid", ValidOut_SO, 1'b1);
        check("t3_label", LabelOut_DO, 4'd3);

        // Downstream stall: output held, upstream not consumed.
        held = mHv;
        hv   = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 3, hv, 0, acc);
            check("t4_readyLow", ReadyOut_SO, 1'b0);
            check("t4_hold", HypervectorOut_DO, held);
        end
        step(1, 0, 3, hv, 1, acc);
        check("t4_resume", ValidOut_SO, 1'b1);

        // Back-to-back stream: no bubbles.
        doReset(0);
        xfers = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 5, 8'($urandom), 1, acc);
            check("t5_validPattern", ValidOut_SO, (i >= 2) ? 1'b1 : 1'b0);
        end
        step(0, 1, 5, '0, 1, acc);
        check("t5_outputs", xfers, 8);

        // Reset while stalled.
        doReset(0);
        step(1, 0, 2, a, 1, acc);
        step(1, 0, 2, a, 1, acc);
        step(1, 0, 2, a, 0, acc);
        step(1, 0, 2, a, 0, acc);
        check("t6_stalledValid", ValidOut_SO, 1'b1);
        doReset(1);
        check("t6_resetClears", ValidOut_SO, 1'b0);
        step(1, 0, 2, a, 1, acc);
        check("t6_noOut1", ValidOut_SO, 1'b0);
        step(1, 0, 2, a, 1, acc);
        check("t6_noOut2", ValidOut_SO, 1'b0);
        step(1, 0, 2, a, 1, acc);
        check("t6_outAgain", ValidOut_SO, 1'b1);

        // Randomized traffic; an offered sample is held until taken.
        doReset(0);
        curMode  = 0;
        curLabel = 1;
        pending  = 0;
        hv       = '0;
        for (int i = 0; i < 300; i++) begin
            if (!pending) begin
                if ($urandom_range(0, 11) == 0) curLabel = 4'($urandom_range(0, 3));
                if ($urandom_range(0, 29) == 0) curMode = 2'($urandom_range(0, 1));
                hv = 8'($urandom);
            end
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(v, curMode, curLabel, hv, rdy, acc);
            pending = v && !acc;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
